// File: rtl/udma_i2s_rx_arbiter.sv
// udma_i2s_rx_arbiter: merges per-channel I2S RX sample streams onto one uDMA RX
// port. Channels are served round-robin with bursts of up to BURST_LEN beats, and
// every output beat carries its source channel number in out_ch_o.
// Optional per-channel accepted-beat counters are built when UDMA_I2S_ARB_STATS_EN
// is defined. Without it, stats_cnt_o is tied to zero.
//
// Handshake (all streams): a beat transfers on a rising edge where valid and ready
// are both high. A producer holds valid and data stable until the beat transfers.
// in_ready_o never depends on in_valid_i. The output register holds its beat
// stable while out_valid_o=1 and out_ready_i=0.
module udma_i2s_rx_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_i,
    input  logic [NUM_CH-1:0]           ch_en_i,
    input  logic [NUM_CH*32-1:0]        in_data_i,
    input  logic [NUM_CH*2-1:0]         in_datasize_i,
    input  logic [NUM_CH-1:0]           in_valid_i,
    output logic [NUM_CH-1:0]           in_ready_o,
    output logic [31:0]                 out_data_o,
    output logic [1:0]                  out_datasize_o,
    output logic [$clog2(NUM_CH)-1:0]   out_ch_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [$clog2(NUM_CH)-1:0]   grant_o,
    output logic                        busy_o,
    input  logic                        stats_clr_i,
    output logic [NUM_CH*CNT_W-1:0]     stats_cnt_o
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int BL_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] pick;
    logic [CH_W:0]   idx;
    logic            found;
    logic [BL_W-1:0] beat_cnt;
    logic [NUM_CH-1:0] req;
    logic            drain;
    logic            slot_free;
    logic            accept;
    logic            burst_end;
    logic [31:0]     sel_data;
    logic [1:0]      sel_datasize;

    assign req          = in_valid_i & ch_en_i;
    assign drain        = out_valid_o & out_ready_i;
    assign slot_free    = ~out_valid_o | drain;
    assign accept       = (state == GRANT) & in_valid_i[grant] & ch_en_i[grant] & slot_free;
    // A stall on slot_free does not end the burst; only a full burst, a dropped
    // valid or a disabled channel hands the port back to arbitration.
    assign burst_end    = (accept && (beat_cnt == BL_W'(BURST_LEN - 1)))
                          || !in_valid_i[grant] || !ch_en_i[grant];
    assign sel_data     = in_data_i[32*int'(grant) +: 32];
    assign sel_datasize = in_datasize_i[2*int'(grant) +: 2];
    assign grant_o      = grant;
    assign busy_o       = (state == GRANT);

    // Round-robin pick: first requesting channel after last_grant, wrapping modulo NUM_CH.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = {1'b0, last_grant} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end
            if (!found && req[idx[CH_W-1:0]]) begin
                pick  = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Only the granted, enabled channel sees ready, and only when the output slot frees up.
    always_comb begin
        in_ready_o        = '0;
        in_ready_o[grant] = (state == GRANT) && ch_en_i[grant] && slot_free;
    end

    // Arbitration FSM: IDLE picks a channel, GRANT streams a burst from it.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= GRANT;
                        grant      <= pick;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (burst_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on accept, empty on a drain without a refill, hold otherwise.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_datasize_o <= '0;
            out_ch_o       <= '0;
        end else if (accept) begin
            out_valid_o    <= 1'b1;
            out_data_o     <= sel_data;
            out_datasize_o <= sel_datasize;
            out_ch_o       <= grant;
        end else if (drain) begin
            out_valid_o    <= 1'b0;
        end
    end

`ifdef UDMA_I2S_ARB_STATS_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
        logic [CNT_W-1:0] cnt;

        // Saturating count of beats accepted from this channel; clear wins over increment.
        always_ff @(posedge sys_clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (stats_clr_i) begin
                cnt <= '0;
            end else if (accept && (grant == CH_W'(g)) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stats_cnt_o[g*CNT_W +: CNT_W] = cnt;
    end
`else
    logic stats_unused;
    assign stats_unused = stats_clr_i;
    assign stats_cnt_o  = '0;
`endif

endmodule
